reg_write_arbiter: RTL and testbench

Shares the single write port of the in-waiting register buffers between two requesters: the SPI command decoder (A) and the internal demo/animation sequencer (B). Grants one register write at a time, tracks whether any buffer has changed since the last commit, and issues the `load_new` pulse that copies the buffers into the live registers at the next frame boundary. It sits between the requesters and the register bank, and is driven by the VGA timing block's vblank pulse.

---
 rtl/reg_write_arbiter.sv | 123 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester arbiter for the register-buffer write port, plus frame-boundary commit logic.
// Define REGARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise A has fixed priority.
module reg_write_arbiter #(
    parameter int unsigned CMD_BITS  = 4,
    parameter int unsigned DATA_BITS = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic [CMD_BITS-1:0]  a_cmd,
    input  logic [DATA_BITS-1:0] a_data,
    output logic                 a_ack,
    input  logic                 b_req,
    input  logic [CMD_BITS-1:0]  b_cmd,
    input  logic [DATA_BITS-1:0] b_data,
    output logic                 b_ack,
    input  logic                 vblank_start,
    input  logic                 commit_hold,
    output logic                 wr_en,
    output logic [CMD_BITS-1:0]  wr_cmd,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 load_new,
    output logic                 pending,
    output logic [7:0]           commit_count
);

    typedef enum logic {StIdle, StWrite} state_e;

    state_e               state_q;
    logic                 a_ack_q, b_ack_q, wr_en_q, load_new_q, pending_q;
    logic [CMD_BITS-1:0]  wr_cmd_q;
    logic [DATA_BITS-1:0] wr_data_q;
    logic [7:0]           commit_count_q;
`ifdef REGARB_ROUND_ROBIN_EN
    logic                 last_grant_b_q;
`endif

    logic a_elig, b_elig, grant_a, grant_b;
    logic load_new_d, pending_d;

    always_comb begin
        // A requester still holds req during its ack cycle; it must not win again then.
        a_elig = a_req & ~a_ack_q;
        b_elig = b_req & ~b_ack_q;
`ifdef REGARB_ROUND_ROBIN_EN
        grant_a = a_elig & (~b_elig | last_grant_b_q);
`else
        grant_a = a_elig;
`endif
        grant_b = b_elig & ~grant_a;

        load_new_d = vblank_start & ~commit_hold & (pending_q | wr_en_q);
        // A write landing on the commit edge belongs to the next frame.
        if (wr_en_q) begin
            pending_d = 1'b1;
        end else if (load_new_q) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            a_ack_q        <= 1'b0;
            b_ack_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_cmd_q       <= '0;
            wr_data_q      <= '0;
            load_new_q     <= 1'b0;
            pending_q      <= 1'b0;
            commit_count_q <= 8'd0;
`ifdef REGARB_ROUND_ROBIN_EN
            last_grant_b_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_a || grant_b) begin
                        state_q   <= StWrite;
                        wr_en_q   <= 1'b1;
                        a_ack_q   <= grant_a;
                        b_ack_q   <= grant_b;
                        wr_cmd_q  <= grant_a ? a_cmd : b_cmd;
                        wr_data_q <= grant_a ? a_data : b_data;
`ifdef REGARB_ROUND_ROBIN_EN
                        last_grant_b_q <= grant_b;
`endif
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                    wr_en_q <= 1'b0;
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    wr_en_q <= 1'b0;
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                end
            endcase

            load_new_q <= load_new_d;
            pending_q  <= pending_d;
            if (load_new_d) begin
                commit_count_q <= commit_count_q + 8'd1;
            end
        end
    end

    assign a_ack        = a_ack_q;
    assign b_ack        = b_ack_q;
    assign wr_en        = wr_en_q;
    assign wr_cmd       = wr_cmd_q;
    assign wr_data      = wr_data_q;
    assign load_new     = load_new_q;
    assign pending      = pending_q;
    assign commit_count = commit_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, single write, commit, collision, hold, wrap, tie.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, b_req, vblank_start, commit_hold;
    logic [3:0]  a_cmd, b_cmd;
    logic [23:0] a_data, b_data;
    logic        a_ack, b_ack, wr_en, load_new, pending;
    logic [3:0]  wr_cmd;
    logic [23:0] wr_data;
    logic [7:0]  commit_count;

    int n_err = 0;
    int n_chk = 0;

    reg_write_arbiter #(.CMD_BITS(4), .DATA_BITS(24)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .a_req        (a_req),
        .a_cmd        (a_cmd),
        .a_data       (a_data),
        .a_ack        (a_ack),
        .b_req        (b_req),
        .b_cmd        (b_cmd),
        .b_data       (b_data),
        .b_ack        (b_ack),
        .vblank_start (vblank_start),
        .commit_hold  (commit_hold),
        .wr_en        (wr_en),
        .wr_cmd       (wr_cmd),
        .wr_data      (wr_data),
        .load_new     (load_new),
        .pending      (pending),
        .commit_count (commit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int          n;
    int          nw;
    int          ai, bi;
    logic [3:0]  got_cmd [8];
    logic [23:0] got_data [8];
    logic [3:0]  exp_cmd;
    logic [23:0] exp_data;

    initial begin
        reset_n = 1'b0;
        a_req = 1'b0; a_cmd = '0; a_data = '0;
        b_req = 1'b0; b_cmd = '0; b_data = '0;
        vblank_start = 1'b0; commit_hold = 1'b0;
        repeat (2) tick();
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_a_ack", {31'd0, a_ack}, 32'd0);
        check("rst_b_ack", {31'd0, b_ack}, 32'd0);
        check("rst_load_new", {31'd0, load_new}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_count", {24'd0, commit_count}, 32'd0);
        check("rst_wr_cmd", {28'd0, wr_cmd}, 32'd0);
        check("rst_wr_data", {8'd0, wr_data}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single writer
        a_req = 1'b1; a_cmd = 4'd3; a_data = 24'h000ABC;
        tick();
        check("single_wr_en", {31'd0, wr_en}, 32'd1);
        check("single_wr_cmd", {28'd0, wr_cmd}, 32'd3);
        check("single_wr_data", {8'd0, wr_data}, 32'h000ABC);
        check("single_a_ack", {31'd0, a_ack}, 32'd1);
        check("single_b_ack", {31'd0, b_ack}, 32'd0);
        a_req = 1'b0;
        tick();
        check("single_wr_en_off", {31'd0, wr_en}, 32'd0);
        check("single_a_ack_off", {31'd0, a_ack}, 32'd0);
        check("single_pending", {31'd0, pending}, 32'd1);

        // Commit, then an empty vblank
        vblank_start = 1'b1;
        tick();
        check("commit_load_new", {31'd0, load_new}, 32'd1);
        check("commit_count1", {24'd0, commit_count}, 32'd1);
        vblank_start = 1'b0;
        tick();
        check("commit_load_new_off", {31'd0, load_new}, 32'd0);
        check("commit_pending_clr", {31'd0, pending}, 32'd0);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        check("empty_vblank_no_load", {31'd0, load_new}, 32'd0);
        check("empty_vblank_count", {24'd0, commit_count}, 32'd1);

        // Reset in the middle of a write cycle
        a_req = 1'b1; a_cmd = 4'd5; a_data = 24'h000055;
        tick();
        check("midwr_wr_en", {31'd0, wr_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midwr_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("midwr_rst_a_ack", {31'd0, a_ack}, 32'd0);
        check("midwr_rst_count", {24'd0, commit_count}, 32'd0);
        check("midwr_rst_wr_cmd", {28'd0, wr_cmd}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("reissue_wr_en", {31'd0, wr_en}, 32'd1);
        check("reissue_a_ack", {31'd0, a_ack}, 32'd1);
        check("reissue_wr_cmd", {28'd0, wr_cmd}, 32'd5);
        a_req = 1'b0;
        n = 0;
        repeat (4) begin
            tick();
            if (wr_en) n++;
        end
        check("reissue_once", n, 32'd0);

        // Write coinciding with the load_new cycle
        vblank_start = 1'b1;
        a_req = 1'b1; a_cmd = 4'd6; a_data = 24'h000066;
        tick();
        check("coll_load_new", {31'd0, load_new}, 32'd1);
        check("coll_wr_en", {31'd0, wr_en}, 32'd1);
        check("coll_count", {24'd0, commit_count}, 32'd1);
        a_req = 1'b0; vblank_start = 1'b0;
        tick();
        check("coll_pending_kept", {31'd0, pending}, 32'd1);
        check("coll_load_new_off", {31'd0, load_new}, 32'd0);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        check("coll_next_load_new", {31'd0, load_new}, 32'd1);
        check("coll_next_count", {24'd0, commit_count}, 32'd2);
        tick();
        check("coll_next_pending", {31'd0, pending}, 32'd0);

        // Hold across three vblanks
        a_req = 1'b1; a_cmd = 4'd7; a_data = 24'h000077;
        tick();
        a_req = 1'b0;
        tick();
        check("hold_pending_pre", {31'd0, pending}, 32'd1);
        commit_hold = 1'b1;
        n = 0;
        repeat (3) begin
            vblank_start = 1'b1;
            tick();
            vblank_start = 1'b0;
            if (load_new) n++;
            tick();
            if (load_new) n++;
        end
        check("hold_no_load", n, 32'd0);
        check("hold_pending", {31'd0, pending}, 32'd1);
        check("hold_count", {24'd0, commit_count}, 32'd2);
        commit_hold = 1'b0;

        // Count from 2 up through 255 and wrap to 0
        n = 0;
        for (int i = 0; i < 254; i++) begin
            a_req = 1'b1; a_cmd = 4'(i); a_data = 24'(i);
            tick();
            a_req = 1'b0; vblank_start = 1'b1;
            tick();
            vblank_start = 1'b0;
            if (load_new) n++;
            if (i == 252) check("wrap_count255", {24'd0, commit_count}, 32'd255);
        end
        check("wrap_pulses", n, 32'd254);
        check("wrap_count0", {24'd0, commit_count}, 32'd0);

        // Tie between both requesters, starting from reset state
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        ai = 0; bi = 0; nw = 0;
        a_req = 1'b1; a_cmd = 4'd1; a_data = 24'h000101;
        b_req = 1'b1; b_cmd = 4'd8; b_data = 24'h000208;
        repeat (30) begin
            tick();
            if (wr_en) begin
                if (nw < 8) begin
                    got_cmd[nw]  = wr_cmd;
                    got_data[nw] = wr_data;
                end
                nw++;
            end
            if (a_ack) begin
                ai++;
                if (ai == 4) a_req = 1'b0;
                else begin
                    a_cmd  = 4'(1 + ai);
                    a_data = 24'(32'h101 + ai);
                end
            end
            if (b_ack) begin
                bi++;
                if (bi == 4) b_req = 1'b0;
                else begin
                    b_cmd  = 4'(8 + bi);
                    b_data = 24'(32'h208 + bi);
                end
            end
        end
        check("tie_write_total", nw, 32'd8);
        for (int k = 0; k < 8; k++) begin
`ifdef REGARB_ROUND_ROBIN_EN
            exp_cmd = (k % 2 == 0) ? 4'(1 + k / 2) : 4'(8 + k / 2);
`else
            exp_cmd = (k < 4) ? 4'(1 + k) : 4'(8 + k - 4);
`endif
            exp_data = (exp_cmd < 4'd8) ? 24'(32'h100 + exp_cmd) : 24'(32'h200 + exp_cmd);
            if (k < nw) begin
                check($sformatf("tie_cmd%0d", k), {28'd0, got_cmd[k]}, {28'd0, exp_cmd});
                check($sformatf("tie_data%0d", k), {8'd0, got_data[k]}, {8'd0, exp_data});
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
